// File: rtl/pzbcm_slicer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pzbcm_slicer_pkg
//  Description : Shared stage-mode type and sizing helpers for the elastic
//                slicer and its stage unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package pzbcm_slicer_pkg;

    typedef enum logic {
        HALF = 1'b0,
        FULL = 1'b1
    } slicer_mode_e;

    function automatic int calc_entries(input int stages, input int full_bandwidth);
        return stages * ((full_bandwidth != 0) ? 2 : 1);
    endfunction

    // Clamped to one bit so the count port stays legal in pass-through mode.
    function automatic int calc_count_width(input int entries);
        int w;
        w = $clog2(entries + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : pzbcm_slicer_pkg
`default_nettype wire

// File: rtl/pzbcm_elastic_slicer_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pzbcm_elastic_slicer_unit
//  Description : One valid/ready register stage: a 2-entry skid buffer in
//                full-bandwidth mode or a 1-entry half-bandwidth register.
//  Revision    : 1.0 - initial release
// ============================================================================
module pzbcm_elastic_slicer_unit
    import pzbcm_slicer_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int FULL_BANDWIDTH = 1,
    parameter int DISABLE_MBFF   = 0
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    localparam slicer_mode_e c_MODE      = (FULL_BANDWIDTH != 0) ? FULL : HALF;
    localparam int           c_DEPTH     = (c_MODE == FULL) ? 2 : 1;
    localparam logic [1:0]   c_DEPTH_CNT = 2'(c_DEPTH);

    logic [1:0]         r_count;
    logic [1:0]         w_count_next;
    logic               w_push;
    logic               w_pop;
    logic [c_DEPTH-1:0] w_wen;
    logic [WIDTH-1:0]   w_wdata [c_DEPTH];
    logic [WIDTH-1:0]   w_entry [c_DEPTH];

    // Ready depends only on the count register (plus the flush), never on i_ready.
    assign o_valid = (r_count != 2'd0);
    assign o_ready = (r_count != c_DEPTH_CNT) && !i_clear;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;
    assign o_data  = w_entry[0];
    assign o_count = r_count;

    always_comb begin
        w_count_next = r_count;
        if (i_clear) begin
            w_count_next = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + 2'd1;
                2'b01:   w_count_next = r_count - 2'd1;
                default: w_count_next = r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 2'd0;
        end else begin
            r_count <= w_count_next;
        end
    end

    generate
        if (c_MODE == FULL) begin : g_full
            // Entry 0 is the head; entry 1 only fills while the head is stalled.
            always_comb begin
                w_wen      = '0;
                w_wdata[0] = i_data;
                w_wdata[1] = i_data;
                if (w_pop && (r_count == 2'd2)) begin
                    w_wen[0]   = 1'b1;
                    w_wdata[0] = w_entry[1];
                end else if (w_push && ((r_count == 2'd0) || w_pop)) begin
                    w_wen[0] = 1'b1;
                end
                if (w_push && !w_pop && (r_count == 2'd1)) begin
                    w_wen[1] = 1'b1;
                end
            end
        end else begin : g_half
            assign w_wen[0]   = w_push;
            assign w_wdata[0] = i_data;
        end

        for (genvar e = 0; e < c_DEPTH; e++) begin : g_entry
            if (DISABLE_MBFF != 0) begin : g_bitwise
                logic [WIDTH-1:0] w_bits;
                for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                    logic r_bit;
                    always_ff @(posedge i_clk) begin
                        if (w_wen[e]) begin
                            r_bit <= w_wdata[e][b];
                        end
                    end
                    assign w_bits[b] = r_bit;
                end
                assign w_entry[e] = w_bits;
            end else begin : g_vector
                logic [WIDTH-1:0] r_word;
                always_ff @(posedge i_clk) begin
                    if (w_wen[e]) begin
                        r_word <= w_wdata[e];
                    end
                end
                assign w_entry[e] = r_word;
            end
        end
    endgenerate

endmodule : pzbcm_elastic_slicer_unit
`default_nettype wire

// File: rtl/pzbcm_elastic_slicer.sv
`default_nettype none
// ============================================================================
//  Module      : pzbcm_elastic_slicer
//  Description : Cascade of STAGES valid/ready slicer stages with occupancy
//                count and per-stage valid flags; STAGES=0 is a wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module pzbcm_elastic_slicer
    import pzbcm_slicer_pkg::*;
#(
    parameter int  WIDTH           = 32,
    parameter int  STAGES          = 1,
    parameter int  FULL_BANDWIDTH  = 1,
    parameter int  ASCENDING_ORDER = 1,
    parameter int  DISABLE_MBFF    = 0,
    localparam int ENTRIES         = calc_entries(STAGES, FULL_BANDWIDTH),
    localparam int COUNT_WIDTH     = calc_count_width(ENTRIES),
    localparam int STAGE_FLAGS     = (STAGES > 0) ? STAGES : 1
)(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic [STAGE_FLAGS-1:0] o_stage_valid
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic w_unused;
            assign w_unused      = ^{i_clk, i_rst_n, i_clear};
            assign o_valid       = i_valid;
            assign o_ready       = i_ready;
            assign o_data        = i_data;
            assign o_count       = '0;
            assign o_stage_valid = '0;
        end else begin : g_pipe
            logic                   w_valid       [STAGES+1];
            logic                   w_ready       [STAGES+1];
            logic [WIDTH-1:0]       w_data        [STAGES+1];
            logic [1:0]             w_stage_count [STAGES];
            logic [COUNT_WIDTH-1:0] w_sum;

            // Link index s feeds stage s; link STAGES is the downstream port.
            assign w_valid[0]      = i_valid;
            assign w_data[0]       = i_data;
            assign o_ready         = w_ready[0];
            assign o_valid         = w_valid[STAGES];
            assign o_data          = w_data[STAGES];
            assign w_ready[STAGES] = i_ready;

            for (genvar s = 0; s < STAGES; s++) begin : g_stage
                pzbcm_elastic_slicer_unit #(
                    .WIDTH          (WIDTH),
                    .FULL_BANDWIDTH (FULL_BANDWIDTH),
                    .DISABLE_MBFF   (DISABLE_MBFF)
                ) u_unit (
                    .i_clk   (i_clk),
                    .i_rst_n (i_rst_n),
                    .i_clear (i_clear),
                    .i_valid (w_valid[s]),
                    .o_ready (w_ready[s]),
                    .i_data  (w_data[s]),
                    .o_valid (w_valid[s+1]),
                    .i_ready (w_ready[s+1]),
                    .o_data  (w_data[s+1]),
                    .o_count (w_stage_count[s])
                );

                assign o_stage_valid[(ASCENDING_ORDER != 0) ? s : (STAGES - 1 - s)] =
                    (w_stage_count[s] != 2'd0);
            end

            always_comb begin
                w_sum = '0;
                for (int s = 0; s < STAGES; s++) begin
                    w_sum = w_sum + COUNT_WIDTH'(w_stage_count[s]);
                end
            end
            assign o_count = w_sum;
        end
    endgenerate

endmodule : pzbcm_elastic_slicer
`default_nettype wire

// File: tb/tb_pzbcm_elastic_slicer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pzbcm_elastic_slicer
//  Description : Directed scoreboard bench for full, half and bypass slicers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pzbcm_elastic_slicer;

    logic clk;
    logic rst_n;

    logic       f_clear, f_valid, f_oready, f_ovalid, f_iready;
    logic [7:0] f_data, f_odata;
    logic [2:0] f_count;
    logic [1:0] f_sv;

    logic       h_valid, h_oready, h_ovalid, h_iready;
    logic [7:0] h_data, h_odata;
    logic [1:0] h_count;
    logic [2:0] h_sv;

    logic       p_valid, p_oready, p_ovalid, p_iready;
    logic [7:0] p_data, p_odata;
    logic [0:0] p_count;
    logic [0:0] p_sv;

    logic       c_zero;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] f_q[$];
    logic [7:0] h_q[$];
    int         f_popped = 0;
    int         h_popped = 0;
    int         h_pushed = 0;
    logic       f_acc    = 1'b0;
    logic       h_acc    = 1'b0;

    assign c_zero = 1'b0;

    pzbcm_elastic_slicer #(
        .WIDTH(8), .STAGES(2), .FULL_BANDWIDTH(1), .ASCENDING_ORDER(1), .DISABLE_MBFF(0)
    ) u_dut_full (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(f_clear),
        .i_valid(f_valid), .o_ready(f_oready), .i_data(f_data),
        .o_valid(f_ovalid), .i_ready(f_iready), .o_data(f_odata),
        .o_count(f_count), .o_stage_valid(f_sv)
    );

    pzbcm_elastic_slicer #(
        .WIDTH(8), .STAGES(3), .FULL_BANDWIDTH(0), .ASCENDING_ORDER(0), .DISABLE_MBFF(1)
    ) u_dut_half (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(c_zero),
        .i_valid(h_valid), .o_ready(h_oready), .i_data(h_data),
        .o_valid(h_ovalid), .i_ready(h_iready), .o_data(h_odata),
        .o_count(h_count), .o_stage_valid(h_sv)
    );

    pzbcm_elastic_slicer #(
        .WIDTH(8), .STAGES(0), .FULL_BANDWIDTH(1), .ASCENDING_ORDER(1), .DISABLE_MBFF(0)
    ) u_dut_pass (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(c_zero),
        .i_valid(p_valid), .o_ready(p_oready), .i_data(p_data),
        .o_valid(p_ovalid), .i_ready(p_iready), .o_data(p_odata),
        .o_count(p_count), .o_stage_valid(p_sv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Samples both handshakes just after the falling edge, then advances one cycle.
    task automatic tick();
        logic [7:0] exp;
        #1;
        f_acc = f_valid && f_oready;
        h_acc = h_valid && h_oready;
        if (f_acc) f_q.push_back(f_data);
        if (h_acc) begin
            h_q.push_back(h_data);
            h_pushed++;
        end
        if (f_ovalid && f_iready) begin
            exp = (f_q.size() != 0) ? f_q.pop_front() : 8'hxx;
            chk("f_data_order", f_odata, exp);
            f_popped++;
        end
        if (h_ovalid && h_iready) begin
            exp = (h_q.size() != 0) ? h_q.pop_front() : 8'hxx;
            chk("h_data_order", h_odata, exp);
            h_popped++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        f_clear = 1'b0; f_valid = 1'b0; f_iready = 1'b0; f_data = 8'h00;
        h_valid = 1'b0; h_iready = 1'b0; h_data = 8'h00;
        p_valid = 1'b0; p_iready = 1'b1; p_data = 8'h00;

        // Reset state
        @(negedge clk);
        chk("rst_f_ovalid", f_ovalid, 0);
        chk("rst_f_count",  f_count,  0);
        chk("rst_f_sv",     f_sv,     0);
        chk("rst_f_oready", f_oready, 1);
        chk("rst_h_oready", h_oready, 1);
        chk("rst_h_count",  h_count,  0);
        chk("rst_p_oready", p_oready, 1);
        rst_n = 1'b1;
        tick();

        // Streaming, full bandwidth
        f_iready = 1'b1;
        f_popped = 0;
        for (int n = 0; n < 20; n++) begin
            f_valid = (n < 16);
            f_data  = 8'(n + 1);
            if (n == 1) begin
                chk("f_stream_lat_valid", f_ovalid, 0);
                chk("f_stream_lat_count", f_count, 1);
            end
            if (n >= 2 && n <= 17) chk("f_stream_valid", f_ovalid, 1);
            if (n >= 2 && n <= 16) chk("f_stream_count", f_count, 2);
            tick();
        end
        f_valid = 1'b0;
        chk("f_stream_beats", f_popped, 16);
        chk("f_stream_empty", f_count, 0);

        // Backpressure: four accepted, fifth stalls
        f_popped = 0;
        f_iready = 1'b0;
        f_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            f_data = 8'(8'h21 + k);
            chk("f_bp_ready", f_oready, 1);
            tick();
        end
        f_data = 8'h25;
        chk("f_bp_full_ready", f_oready, 0);
        chk("f_bp_full_count", f_count, 4);
        chk("f_bp_full_sv",    f_sv, 2'b11);
        tick();
        tick();
        chk("f_bp_hold_ready", f_oready, 0);
        f_iready = 1'b1;
        #1;
        chk("f_pop_at_full_ready", f_oready, 0);
        for (int n = 0; n < 20 && (f_valid || f_q.size() != 0 || f_ovalid); n++) begin
            tick();
            if (f_acc) f_valid = 1'b0;
        end
        chk("f_bp_fifth_accepted", f_valid, 0);
        chk("f_bp_beats", f_popped, 5);
        chk("f_bp_sb_empty", f_q.size(), 0);

        // Flush with a coincident push
        f_iready = 1'b0;
        f_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            f_data = 8'(8'h31 + k);
            tick();
        end
        f_data   = 8'h3F;
        f_clear  = 1'b1;
        f_iready = 1'b1;
        #1;
        chk("f_clr_ready", f_oready, 0);
        chk("f_clr_count_before", f_count, 3);
        tick();
        f_clear = 1'b0;
        f_valid = 1'b0;
        f_q.delete();
        chk("f_clr_count_after", f_count, 0);
        chk("f_clr_sv_after", f_sv, 0);
        for (int n = 0; n < 6; n++) begin
            chk("f_clr_no_stale", f_ovalid, 0);
            tick();
        end

        // Half bandwidth, three stages, descending stage flags
        h_iready = 1'b1;
        h_valid  = 1'b1;
        h_data   = 8'h50;
        for (int n = 0; n < 30; n++) begin
            if (n == 1) chk("h_sv_input_stage", h_sv, 3'b100);
            if (n == 2) chk("h_latency_valid", h_ovalid, 0);
            if (n >= 3) chk("h_cadence", h_ovalid, ((n - 3) % 2) == 0);
            if (n >= 1) chk("h_count", h_count, (n < 3) ? 1 : (((n % 2) == 1) ? 2 : 1));
            tick();
            if (h_acc) h_data = h_data + 8'h01;
        end
        h_valid = 1'b0;
        for (int n = 0; n < 8; n++) tick();
        chk("h_beats", h_popped, h_pushed);
        chk("h_sb_empty", h_q.size(), 0);

        // Asynchronous reset mid-stream
        f_iready = 1'b0;
        f_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            f_data = 8'(8'h41 + k);
            tick();
        end
        f_valid = 1'b0;
        chk("f_rst_pre_count", f_count, 3);
        rst_n = 1'b0;
        #1;
        chk("f_rst_async_valid",  f_ovalid, 0);
        chk("f_rst_async_count",  f_count, 0);
        chk("f_rst_async_oready", f_oready, 1);
        f_q.delete();
        tick();
        rst_n    = 1'b1;
        f_iready = 1'b1;
        f_valid  = 1'b1;
        f_data   = 8'hA5;
        tick();
        f_valid = 1'b0;
        chk("f_rst_lat1_valid", f_ovalid, 0);
        tick();
        chk("f_rst_lat2_valid", f_ovalid, 1);
        chk("f_rst_lat2_data",  f_odata, 8'hA5);
        tick();
        chk("f_rst_sb_empty", f_q.size(), 0);

        // Zero-stage pass-through
        for (int n = 0; n < 16; n++) begin
            p_valid  = 1'($urandom_range(1, 0));
            p_iready = 1'($urandom_range(1, 0));
            p_data   = 8'($urandom);
            #1;
            chk("p_valid", p_ovalid, p_valid);
            chk("p_ready", p_oready, p_iready);
            chk("p_data",  p_odata,  p_data);
            chk("p_count", p_count,  0);
            chk("p_sv",    p_sv,     0);
            #4;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_pzbcm_elastic_slicer
`default_nettype wire
